// File: rtl/des_encryption.sv
// Iterative DES encryption core: one Feistel round per clock, free-running
// LOAD -> 16 x ROUND -> OUT, so a new ciphertext is published every 18 cycles.
module des_encryption (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:63] plainText,
  input  logic [63:0] key,
  output logic [63:0] encrypted,
  output logic        done
);

  typedef enum logic [1:0] {StLoad, StRound, StOut} state_e;

  // All tables use DES bit numbering (bit 1 = MSB of the source vector).
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                              12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23,
                              24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
                                26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
                                51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Each S-box is 64 nibbles, row-major (row*16 + col), entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  state_e      r_state;
  logic [3:0]  r_round;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;

  logic [63:0] w_pt, w_ip, w_fp, w_preout;
  logic [55:0] w_pc1, w_cd_rot;
  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_k, w_e, w_x;
  logic [31:0] w_s, w_f;
  logic        w_shift_one;
  logic        w_unused_parity;

  assign w_pt            = plainText;
  assign w_preout        = {r_r, r_l};
  assign w_unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

  assign w_shift_one = (r_round == 4'd1) || (r_round == 4'd2) ||
                       (r_round == 4'd9) || (r_round == 4'd16);
  assign w_c_rot  = w_shift_one ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
  assign w_d_rot  = w_shift_one ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
  assign w_cd_rot = {w_c_rot, w_d_rot};
  assign w_x      = w_e ^ w_k;

  always_comb begin
    w_ip  = '0;
    w_fp  = '0;
    w_pc1 = '0;
    w_k   = '0;
    w_e   = '0;
    w_f   = '0;
    for (int i = 0; i < 64; i++) begin
      w_ip[63-i] = w_pt[64-IP_T[i]];
      w_fp[63-i] = w_preout[64-FP_T[i]];
    end
    for (int i = 0; i < 56; i++) w_pc1[55-i] = key[64-PC1_T[i]];
    for (int i = 0; i < 48; i++) begin
      w_k[47-i] = w_cd_rot[56-PC2_T[i]];
      w_e[47-i] = r_r[32-E_T[i]];
    end
    for (int i = 0; i < 32; i++) w_f[31-i] = w_s[32-P_T[i]];
  end

  // Row = outer bits {1,6}, column = inner bits {2..5} of each 6-bit group.
  always_comb begin
    int idx;
    w_s = '0;
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      idx = int'({w_x[47-6*s], w_x[42-6*s], w_x[(46-6*s) -: 4]});
      w_s[(31-4*s) -: 4] = 4'(SBOX[s] >> (4 * (63 - idx)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StLoad;
      r_round   <= 4'd0;
      r_l       <= '0;
      r_r       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      encrypted <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StLoad: begin
          {r_l, r_r} <= w_ip;
          {r_c, r_d} <= w_pc1;
          r_round    <= 4'd1;
          r_state    <= StRound;
        end
        StRound: begin
          r_c <= w_c_rot;
          r_d <= w_d_rot;
          r_l <= r_r;
          r_r <= r_l ^ w_f;
          if (r_round == 4'd16) r_state <= StOut;
          else                  r_round <= r_round + 4'd1;
        end
        StOut: begin
          encrypted <= w_fp;
          done      <= 1'b1;
          r_state   <= StLoad;
        end
        default: r_state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_des_encryption.sv
// Directed-vector bench for des_encryption: known-answer vectors, 18-cycle
// cadence, input isolation during rounds, and mid-block reset.
module tb_des_encryption;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:63] pt;
  logic [63:0] key;
  logic [63:0] enc;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int n;
  logic [63:0] c_ascii;

  always #50 clk = ~clk;

  des_encryption dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .plainText (pt),
    .key       (key),
    .encrypted (enc),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen, bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (done !== 1'b1 && cnt < 40);
  endtask

  // Call just after a done edge: the next edge is LOAD, done follows 18 edges later.
  task automatic run(input string tag, input logic [63:0] k, input logic [63:0] p,
                     input logic [63:0] exp);
    int cnt;
    key = k;
    pt  = p;
    wait_done(cnt);
    check_eq({tag, "_lat"}, 64'(cnt), 64'd18);
    check_eq(tag, enc, exp);
  endtask

  initial begin
    key = {$urandom, $urandom};
    pt  = {$urandom, $urandom};
    repeat (3) tick();
    check_eq("rst_enc", enc, 64'h0);
    check_eq("rst_done", {63'b0, done}, 64'h0);

    key = 64'h133457799BBCDFF1;
    pt  = 64'h0123456789ABCDEF;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(n);
    check_eq("first_lat", 64'(n), 64'd18);
    check_eq("std_vec", enc, 64'h85E813540F0AB405);
    tick();
    check_eq("done_pulse", {63'b0, done}, 64'h0);
    check_eq("enc_hold", enc, 64'h85E813540F0AB405);
    wait_done(n);

    run("kat_zero", 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000);
    run("weak_0101", 64'h0101010101010101, 64'h95F8A5E5DD31D900, 64'h8000000000000000);
    run("parity_0000", 64'h0000000000000000, 64'h95F8A5E5DD31D900, 64'h8000000000000000);
    // Complementation property applied to the weak-key vector.
    run("compl_fefe", 64'hFEFEFEFEFEFEFEFE, 64'h6A075A1A22CE26FF, 64'h7FFFFFFFFFFFFFFF);
    // A weak key makes encryption an involution.
    run("weak_inv", 64'h0101010101010101, 64'h8000000000000000, 64'h95F8A5E5DD31D900);

    key = 64'h0C0C0C0C0C0C0C0C;
    pt  = 64'h3132333435363738;
    wait_done(n);
    check_eq("ascii_lat", 64'(n), 64'd18);
    c_ascii = enc;
    wait_done(n);
    check_eq("ascii_period", 64'(n), 64'd18);
    check_eq("ascii_repeat", enc, c_ascii);
    run("ascii_compl", 64'hF3F3F3F3F3F3F3F3, 64'hCECDCCCBCAC9C8C7, ~c_ascii);

    key = 64'h0101010101010101;
    pt  = 64'h95F8A5E5DD31D900;
    tick();
    repeat (4) tick();
    pt = 64'hDD7F121CA5015619;
    wait_done(n);
    check_eq("midchg_lat", 64'(n), 64'd13);
    check_eq("midchg_inflight", enc, 64'h8000000000000000);
    wait_done(n);
    check_eq("midchg_next", enc, 64'h4000000000000000);

    key = 64'h133457799BBCDFF1;
    pt  = 64'h0123456789ABCDEF;
    tick();
    repeat (8) tick();
    #20;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_enc", enc, 64'h0);
    check_eq("midrst_done", {63'b0, done}, 64'h0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(n);
    check_eq("midrst_lat", 64'(n), 64'd18);
    check_eq("midrst_vec", enc, 64'h85E813540F0AB405);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
